instruction_fetch_module: RTL and testbench

- Program memory plus fetch sequencer; drives selector0/selector1 into instruction_module and consumes its program_counter.
- Host loads the program over a valid/ready write port while the core is stopped, then pulses start.
- Each cycle the word at program_counter is fetched and decoded into selector fields; all-ones selectors are presented whenever the core must not select (idle, halted, fault).

---
 rtl/instruction_fetch_module.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_module.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_module.sv
// Program memory and fetch sequencer feeding instruction_module's selectors.
// Control and loading run on posedge; fetch/decode runs on negedge so selectors settle before the core samples them.
`ifndef COUNTER_WIDTH
`define COUNTER_WIDTH 8
`endif

module instruction_fetch_module #(
  parameter int count0 = 0,
  parameter int count1 = 0,
  parameter int depth  = 256,
  localparam int cw    = `COUNTER_WIDTH,
  localparam int s0w   = (count0 < 1) ? 1 : $clog2(count0 + 1),
  localparam int s1w   = (count1 < 1) ? 1 : $clog2(count1 + 1),
  localparam int ww    = s0w + s1w + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [cw-1:0]  program_counter,
  input  logic           start,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [cw-1:0]  load_address,
  input  logic [ww-1:0]  load_data,
  output logic [s0w-1:0] selector0,
  output logic [s1w-1:0] selector1,
  output logic           running,
  output logic           halted,
  output logic           fault,
  output logic [cw-1:0]  retired
);

  localparam int aw = (depth < 2) ? 1 : $clog2(depth);
  localparam logic [cw:0] depth_ext = (cw + 1)'(depth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t state, state_next;

  logic [ww-1:0] mem [depth];
  logic [ww-1:0] word;

  logic          load_fire, load_in_range, start_fire, fetch_in_range;
  logic          fault_q, fetch_stop_q, fetch_fault_q;
  logic          epoch_q, epoch_seen_q;
  logic [cw-1:0] retired_q, retired_base;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next     = state;
    load_ready     = (state != ST_RUN);
    load_fire      = load_valid && load_ready;
    load_in_range  = {1'b0, load_address} < depth_ext;
    start_fire     = start && !load_valid && (state != ST_RUN);
    fetch_in_range = {1'b0, program_counter} < depth_ext;
    word           = mem[program_counter[aw-1:0]];
    retired_base   = (epoch_q != epoch_seen_q) ? '0 : retired_q;
    unique case (state)
      ST_IDLE, ST_HALTED: if (start_fire) state_next = ST_RUN;
      ST_RUN:             if (fetch_stop_q) state_next = ST_HALTED;
      default:            state_next = ST_IDLE;
    endcase
  end

  // Control domain. A start flips epoch_q, which tells the negedge side to restart retired from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      fault_q <= 1'b0;
      epoch_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      if (start_fire) begin
        fault_q <= 1'b0;
        epoch_q <= ~epoch_q;
      end else if ((load_fire && !load_in_range) || fetch_fault_q) begin
        fault_q <= 1'b1;
      end
    end
  end

  // NOTE: the program array is deliberately not reset, so a core reset keeps the loaded program.
  always_ff @(posedge clock) begin
    if (load_fire && load_in_range) mem[load_address[aw-1:0]] <= load_data;
  end

  // Fetch domain: selectors are the registered read of the word at program_counter.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      selector0     <= '1;
      selector1     <= '1;
      fetch_stop_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      retired_q     <= '0;
      epoch_seen_q  <= 1'b0;
    end else begin
      selector0     <= '1;
      selector1     <= '1;
      fetch_stop_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      retired_q     <= retired_base;
      epoch_seen_q  <= epoch_q;
      if (state == ST_RUN) begin
        if (!fetch_in_range) begin
          fetch_stop_q  <= 1'b1;
          fetch_fault_q <= 1'b1;
        end else if (word[ww-1]) begin
          fetch_stop_q <= 1'b1;
        end else begin
          selector0 <= word[s0w-1:0];
          selector1 <= word[s0w+s1w-1:s0w];
          retired_q <= retired_base + cw'(1);
        end
      end
    end
  end

  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALTED);
  assign fault   = fault_q | fetch_fault_q;
  assign retired = retired_base;

endmodule

// File: tb/tb_instruction_fetch_module.sv
// Scoreboard bench: fetch stimulus queues expected selectors/retired/fault, a negedge monitor compares them.
`timescale 1ns/1ps

module tb_instruction_fetch_module;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] program_counter;
  logic       start;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_address;
  logic [4:0] load_data;
  logic [1:0] selector0;
  logic [1:0] selector1;
  logic       running;
  logic       halted;
  logic       fault;
  logic [7:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] s0;
    logic [1:0] s1;
    logic [7:0] ret;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];

  instruction_fetch_module #(.count0(3), .count1(3), .depth(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .program_counter (program_counter),
    .start           (start),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_address    (load_address),
    .load_data       (load_data),
    .selector0       (selector0),
    .selector1       (selector1),
    .running         (running),
    .halted          (halted),
    .fault           (fault),
    .retired         (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every negedge in RUN is a fetch, so one expected record is consumed.
  initial begin
    forever begin
      @(negedge clock);
      if (running === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_fetch: fetch at %0t with no expected entry", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("fetch_selector0", selector0, e.s0);
          check("fetch_selector1", selector1, e.s1);
          check("fetch_retired", retired, e.ret);
          check("fetch_fault", fault, e.flt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [4:0] data);
    load_valid   = 1'b1;
    load_address = addr;
    load_data    = data;
    step();
    load_valid = 1'b0;
  endtask

  task automatic start_pulse(input logic [7:0] pc);
    start           = 1'b1;
    program_counter = pc;
    step();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] pc, input logic [1:0] s0, input logic [1:0] s1,
                       input logic [7:0] ret, input logic flt);
    exp_t e;
    program_counter = pc;
    e = '{s0: s0, s1: s1, ret: ret, flt: flt};
    exp_q.push_back(e);
    step();
  endtask

  initial begin
    reset_n         = 1'b0;
    program_counter = '0;
    start           = 1'b0;
    load_valid      = 1'b0;
    load_address    = '0;
    load_data       = '0;
    repeat (2) step();
    check("reset_selector0", selector0, 2'b11);
    check("reset_selector1", selector1, 2'b11);
    check("reset_running", running, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_retired", retired, 8'd0);
    reset_n = 1'b1;
    step();
    check("idle_load_ready", load_ready, 1'b1);

    // Words are {halt, selector1, selector0}.
    load(8'd0, 5'b0_01_10);
    load(8'd1, 5'b1_00_00);
    load(8'd3, 5'b0_00_11);
    check("idle_running", running, 1'b0);

    start_pulse(8'd0);
    check("start_running", running, 1'b1);
    fetch(8'd0, 2'd2, 2'd1, 8'd1, 1'b0);
    fetch(8'd1, 2'd3, 2'd3, 8'd1, 1'b0);
    check("halt_halted", halted, 1'b1);
    check("halt_running", running, 1'b0);
    check("halt_retired", retired, 8'd1);
    check("halted_load_ready", load_ready, 1'b1);

    // Out-of-range load must fault and must not alias onto address 3.
    load(8'd7, 5'b0_10_10);
    check("oor_load_fault", fault, 1'b1);

    start_pulse(8'd0);
    check("restart_halted", halted, 1'b0);
    check("restart_fault", fault, 1'b0);
    check("restart_retired", retired, 8'd0);
    check("restart_running", running, 1'b1);

    // Write attempt while running is refused.
    load_valid   = 1'b1;
    load_address = 8'd0;
    load_data    = 5'b0_00_11;
    check("run_load_ready", load_ready, 1'b0);
    fetch(8'd0, 2'd2, 2'd1, 8'd1, 1'b0);
    load_valid = 1'b0;
    fetch(8'd3, 2'd3, 2'd0, 8'd2, 1'b0);
    fetch(8'd1, 2'd3, 2'd3, 8'd2, 1'b0);
    check("second_halt", halted, 1'b1);

    start_pulse(8'd0);
    fetch(8'd0, 2'd2, 2'd1, 8'd1, 1'b0);

    // Asynchronous reset in the middle of a RUN cycle.
    program_counter = 8'd2;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_running", running, 1'b0);
    check("async_reset_selector0", selector0, 2'b11);
    check("async_reset_selector1", selector1, 2'b11);
    check("async_reset_retired", retired, 8'd0);
    step();
    reset_n = 1'b1;

    // start coinciding with a write: write wins, start ignored.
    start        = 1'b1;
    load_valid   = 1'b1;
    load_address = 8'd2;
    load_data    = 5'b0_11_01;
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    check("start_with_load_running", running, 1'b0);

    start_pulse(8'd0);
    fetch(8'd0, 2'd2, 2'd1, 8'd1, 1'b0);
    fetch(8'd2, 2'd1, 2'd3, 8'd2, 1'b0);
    fetch(8'd4, 2'd3, 2'd3, 8'd2, 1'b1);
    check("oor_fetch_fault", fault, 1'b1);
    check("oor_fetch_halted", halted, 1'b1);
    check("oor_fetch_selector0", selector0, 2'b11);

    // retired wraps after 256 fetches.
    start_pulse(8'd0);
    check("wrap_restart_fault", fault, 1'b0);
    for (int i = 1; i <= 256; i++) fetch(8'd0, 2'd2, 2'd1, 8'(i), 1'b0);
    check("wrap_retired", retired, 8'd0);
    fetch(8'd1, 2'd3, 2'd3, 8'd0, 1'b0);
    check("wrap_halted", halted, 1'b1);

    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
